quad_multi: RTL and testbench

//   N-channel 4x quadrature decoder for motor encoders. Per channel: 2-FF synchroniser,

---
 rtl/quad_pkg.sv | 47 ++++
 rtl/quad_channel.sv | 134 +++++++++++++
 rtl/quad_multi.sv | 88 ++++++++
 tb/tb_quad_multi.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/quad_pkg.sv
// -----------------------------------------------------------------------------
// quad_pkg
//   Shared types and helpers for the quad_multi encoder decoder.
//   - quad_state_t : 2-bit encoder state, packed as {A,B}
//   - step_t       : result of comparing two successive encoder states
//   - decode_step  : classifies a prev->cur transition as none/up/down/illegal
//   - sat_signed   : clamps a signed value into a signed field of given width
//   Optional velocity path elsewhere is enabled by macro QUAD_VELOCITY_EN.
// -----------------------------------------------------------------------------
package quad_pkg;

    typedef logic [1:0] quad_state_t;

    typedef enum logic [1:0] {
        STEP_NONE    = 2'd0,
        STEP_UP      = 2'd1,
        STEP_DN      = 2'd2,
        STEP_ILLEGAL = 2'd3
    } step_t;

    // Exactly one bit changing is a legal quadrature step; its direction is
    // A_new ^ B_old, which makes 00->10->11->01->00 count upwards.
    function automatic step_t decode_step(input quad_state_t prev, input quad_state_t cur);
        quad_state_t v_diff;
        v_diff = prev ^ cur;
        case (v_diff)
            2'b00:   return STEP_NONE;
            2'b11:   return STEP_ILLEGAL;
            default: return (cur[1] ^ prev[0]) ? STEP_UP : STEP_DN;
        endcase
    endfunction

    // Saturate a signed 32-bit value into [-2^(width-1), 2^(width-1)-1].
    function automatic logic signed [31:0] sat_signed(input logic signed [31:0] in, input int width);
        longint v_max;
        longint v_min;
        v_max = (longint'(1) <<< (width - 1)) - 1;
        v_min = -(longint'(1) <<< (width - 1));
        if (longint'(in) > v_max)
            return 32'(v_max);
        else if (longint'(in) < v_min)
            return 32'(v_min);
        else
            return in;
    endfunction

endpackage

// File: rtl/quad_channel.sv
// -----------------------------------------------------------------------------
// quad_channel
//   One encoder channel: 2-FF synchroniser, per-bit stability debounce,
//   transition decode, wrap-around signed position counter, sticky error flag
//   and (with QUAD_VELOCITY_EN defined) the per-window velocity snapshot.
// Ports
//   clk, reset_n  : clock, asynchronous active-low reset
//   i_quad_a/b    : raw encoder pins, asynchronous to clk
//   i_zero        : synchronous clear of position (and velocity snapshot)
//   i_err_clr     : clear of the sticky error flag
//   i_sample      : window-end strobe from the top (velocity build only)
//   o_count       : signed position
//   o_err         : sticky illegal-transition flag
//   o_vel         : saturated counts in the last window (0 without QUAD_VELOCITY_EN)
// -----------------------------------------------------------------------------
module quad_channel
    import quad_pkg::*;
#(
    parameter int CNT_W          = 24,
    parameter int DEBOUNCE_TICKS = 5,
    parameter int VEL_W          = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    i_quad_a,
    input  logic                    i_quad_b,
    input  logic                    i_zero,
    input  logic                    i_err_clr,
    input  logic                    i_sample,
    output logic signed [CNT_W-1:0] o_count,
    output logic                    o_err,
    output logic signed [VEL_W-1:0] o_vel
);

    localparam int DB_W = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_TICKS - 1);

    quad_state_t             r_sync1;
    quad_state_t             r_sync2;
    quad_state_t             r_deb;
    quad_state_t             r_prev;
    logic [DB_W-1:0]         r_db_cnt [2];
    logic signed [CNT_W-1:0] r_count;
    logic                    r_err;
    step_t                   w_step;

    // Synchroniser and debounce. A debounced bit follows the synchronised bit
    // only after it has disagreed for DEBOUNCE_TICKS consecutive cycles; any
    // cycle of agreement restarts the count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_deb   <= '0;
            for (int i = 0; i < 2; i++) r_db_cnt[i] <= '0;
        end else begin
            r_sync1 <= {i_quad_a, i_quad_b};
            r_sync2 <= r_sync1;
            for (int i = 0; i < 2; i++) begin
                if (r_sync2[i] == r_deb[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_LAST) begin
                    r_deb[i]    <= r_sync2[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    assign w_step = decode_step(r_prev, r_deb);

    // Decode and count. zero overrides a step landing in the same cycle but
    // leaves the previous-state register tracking the encoder.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prev  <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            r_prev <= r_deb;
            if (i_zero)
                r_count <= '0;
            else if (w_step == STEP_UP)
                r_count <= r_count + CNT_W'(1);
            else if (w_step == STEP_DN)
                r_count <= r_count - CNT_W'(1);

            if (w_step == STEP_ILLEGAL)
                r_err <= 1'b1;
            else if (i_err_clr)
                r_err <= 1'b0;
        end
    end

    assign o_count = r_count;
    assign o_err   = r_err;

`ifdef QUAD_VELOCITY_EN
    logic signed [CNT_W-1:0] r_snap;
    logic signed [VEL_W-1:0] r_vel;
    logic signed [CNT_W-1:0] w_delta;
    logic signed [31:0]      w_sat;

    // Wrapped difference is taken at CNT_W bits, then sign-extended so a
    // counter wrap inside the window still yields the small true delta.
    assign w_delta = r_count - r_snap;
    assign w_sat   = sat_signed(32'(w_delta), VEL_W);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_snap <= '0;
            r_vel  <= '0;
        end else begin
            if (i_sample)
                r_vel <= VEL_W'(w_sat);
            // Zeroing moves the snapshot with the count so the jump is not
            // reported as motion.
            if (i_zero)
                r_snap <= '0;
            else if (i_sample)
                r_snap <= r_count;
        end
    end

    assign o_vel = r_vel;
`else
    logic w_unused_sample;
    assign w_unused_sample = i_sample;
    assign o_vel = '0;
`endif

endmodule

// File: rtl/quad_multi.sv
// -----------------------------------------------------------------------------
// quad_multi
//   NUM_CH-channel 4x quadrature decoder for motor encoders. Each channel is a
//   quad_channel instance; this level owns the shared velocity window counter
//   and vel_valid strobe. Velocity is built only when QUAD_VELOCITY_EN is
//   defined; otherwise vel and vel_valid are constant 0.
// Ports
//   clk, reset_n : clock, asynchronous active-low reset
//   quad_a/b     : raw encoder inputs, one bit per channel
//   zero         : per-channel synchronous position clear (level)
//   err_clr      : per-channel sticky-error clear
//   count        : NUM_CH x CNT_W positions, ch0 in LSBs
//   err          : per-channel sticky illegal-transition flag
//   vel          : NUM_CH x VEL_W signed counts per window, ch0 in LSBs
//   vel_valid    : one-cycle pulse when vel is refreshed
// -----------------------------------------------------------------------------
module quad_multi
    import quad_pkg::*;
#(
    parameter int NUM_CH         = 6,
    parameter int CNT_W          = 24,
    parameter int DEBOUNCE_TICKS = 5,
    parameter int CLK_FREQ_HZ    = 32_000_000,
    parameter int VEL_WINDOW     = CLK_FREQ_HZ / 1000,
    parameter int VEL_W          = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_CH-1:0]       quad_a,
    input  logic [NUM_CH-1:0]       quad_b,
    input  logic [NUM_CH-1:0]       zero,
    input  logic [NUM_CH-1:0]       err_clr,
    output logic [NUM_CH*CNT_W-1:0] count,
    output logic [NUM_CH-1:0]       err,
    output logic [NUM_CH*VEL_W-1:0] vel,
    output logic                    vel_valid
);

    logic        w_sample;
    logic [31:0] w_unused_cfg;

    // Clock frequency only feeds the window default; keep it referenced.
    assign w_unused_cfg = 32'(CLK_FREQ_HZ) ^ 32'(VEL_WINDOW);

`ifdef QUAD_VELOCITY_EN
    localparam int WC_W = $clog2(VEL_WINDOW);

    logic [WC_W-1:0] r_win_cnt;
    logic            r_vel_valid;

    assign w_sample = (r_win_cnt == WC_W'(VEL_WINDOW - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_win_cnt   <= '0;
            r_vel_valid <= 1'b0;
        end else begin
            r_win_cnt   <= w_sample ? '0 : r_win_cnt + WC_W'(1);
            r_vel_valid <= w_sample;
        end
    end

    assign vel_valid = r_vel_valid;
`else
    assign w_sample  = 1'b0;
    assign vel_valid = 1'b0;
`endif

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        quad_channel #(
            .CNT_W          (CNT_W),
            .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
            .VEL_W          (VEL_W)
        ) u_channel (
            .clk       (clk),
            .reset_n   (reset_n),
            .i_quad_a  (quad_a[g]),
            .i_quad_b  (quad_b[g]),
            .i_zero    (zero[g]),
            .i_err_clr (err_clr[g]),
            .i_sample  (w_sample),
            .o_count   (count[g*CNT_W +: CNT_W]),
            .o_err     (err[g]),
            .o_vel     (vel[g*VEL_W +: VEL_W])
        );
    end

endmodule

// File: tb/tb_quad_multi.sv
module tb_quad_multi;

    localparam int NUM_CH         = 2;
    localparam int CNT_W          = 8;
    localparam int DEBOUNCE_TICKS = 3;
    localparam int VEL_WINDOW     = 100;
    localparam int VEL_W          = 4;
    localparam int LAT            = 2 + DEBOUNCE_TICKS + 1;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  quad_a, quad_b, zero, err_clr;
    logic [15:0] count;
    logic [1:0]  err;
    logic [7:0]  vel;
    logic        vel_valid;

    quad_multi #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
        .CLK_FREQ_HZ(100_000), .VEL_WINDOW(VEL_WINDOW), .VEL_W(VEL_W)
    ) dut (
        .clk(clk), .reset_n(reset_n), .quad_a(quad_a), .quad_b(quad_b),
        .zero(zero), .err_clr(err_clr), .count(count), .err(err),
        .vel(vel), .vel_valid(vel_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          t_due;
        logic [15:0] cnt;
        logic [1:0]  e;
    } exp_t;

    exp_t        exp_q[$];
    int          vel_q[$];
    logic [1:0]  gray_tab [4];
    int          m_idx [2];
    int          m_pos [2];
    logic [1:0]  m_ab [2];
    logic [1:0]  m_err;
    logic [15:0] last_exp_cnt;
    logic [1:0]  last_exp_err;
    logic [15:0] seen_cnt;
    logic [1:0]  seen_err;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    bit          mon_en = 0;
    bit          vel_chk_en = 0;
    bit          vel_bad = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string nm, input longint act, input longint req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: actual %0d required %0d (cycle %0d)", nm, act, req, cyc);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic int wrap(input int x);
        return ((x % 256) + 256) % 256;
    endfunction

    function automatic int sat4(input int x);
        if (x > 7) return 7;
        if (x < -8) return -8;
        return x;
    endfunction

    function automatic int idx_of(input logic [1:0] s);
        for (int i = 0; i < 4; i++)
            if (gray_tab[i] == s) return i;
        return 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_idx[i] = 0;
            m_pos[i] = 0;
            m_ab[i]  = 2'b00;
        end
        m_err        = 2'b00;
        last_exp_cnt = '0;
        last_exp_err = '0;
    endtask

    task automatic push_expect(input int due);
        logic [15:0] c;
        c = {8'(m_pos[1]), 8'(m_pos[0])};
        if (c !== last_exp_cnt || m_err !== last_exp_err) begin
            exp_q.push_back('{t_due: due, cnt: c, e: m_err});
            last_exp_cnt = c;
            last_exp_err = m_err;
        end
    endtask

    // Drive a new settled pin state on a channel; the model moves the position
    // by the distance travelled around the 4-state Gray cycle.
    task automatic apply(input int ch, input logic [1:0] ns, input int due);
        int ni;
        int d;
        ni = idx_of(ns);
        d  = (ni - m_idx[ch] + 4) % 4;
        if (d == 1) m_pos[ch] = wrap(m_pos[ch] + 1);
        else if (d == 3) m_pos[ch] = wrap(m_pos[ch] - 1);
        else if (d == 2) m_err[ch] = 1'b1;
        m_idx[ch] = ni;
        m_ab[ch]  = ns;
        quad_a[ch] = ns[1];
        quad_b[ch] = ns[0];
        push_expect(due);
    endtask

    task automatic do_step(input int ch, input int dir, input int hold);
        apply(ch, gray_tab[(m_idx[ch] + dir + 4) % 4], cyc + LAT);
        tick(hold);
    endtask

    task automatic zero_pulse(input int ch, input int hold);
        zero[ch]  = 1'b1;
        m_pos[ch] = 0;
        push_expect(cyc + 1);
        tick(1);
        zero[ch] = 1'b0;
        tick(hold);
    endtask

    task automatic clr_pulse(input int ch, input int hold);
        err_clr[ch] = 1'b1;
        m_err[ch]   = 1'b0;
        push_expect(cyc + 1);
        tick(1);
        err_clr[ch] = 1'b0;
        tick(hold);
    endtask

    task automatic glitch(input int ch, input logic [1:0] mask, input int width);
        logic [1:0] g;
        g = m_ab[ch] ^ mask;
        quad_a[ch] = g[1];
        quad_b[ch] = g[0];
        tick(width);
        quad_a[ch] = m_ab[ch][1];
        quad_b[ch] = m_ab[ch][0];
        tick(10);
    endtask

    task automatic wait_vel();
        bit got;
        got = 0;
        for (int k = 0; k < 250 && !got; k++) begin
            @(negedge clk);
            if (vel_valid === 1'b1) got = 1;
        end
        check("vel_pulse_seen", got, 1);
    endtask

    // Monitor: every observed change of count/err must match the next
    // scheduled model event, including the cycle it lands on.
    initial begin
        exp_t e;
        int   v;
        forever begin
            @(negedge clk);
            if (mon_en && (count !== seen_cnt || err !== seen_err)) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_count", count, last_exp_cnt);
                    check("unexpected_err", err, last_exp_err);
                end else begin
                    e = exp_q.pop_front();
                    check("event_cycle", cyc, e.t_due);
                    check("event_count", count, e.cnt);
                    check("event_err", err, e.e);
                end
            end
            seen_cnt = count;
            seen_err = err;
`ifdef QUAD_VELOCITY_EN
            if (vel_chk_en && vel_valid === 1'b1) begin
                if (vel_q.size() == 0) begin
                    check("vel_unexpected_pulse", vel_valid, 0);
                end else begin
                    v = vel_q.pop_front();
                    check("vel0", $signed(vel[3:0]), v);
                    check("vel1", $signed(vel[7:4]), 0);
                end
            end
`else
            if (vel !== 8'h00 || vel_valid !== 1'b0) vel_bad = 1;
`endif
        end
    end

    initial begin
        #300_000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          op, ch, hold, dir, c;
        logic [1:0]  ns, orig;

        gray_tab = '{2'b00, 2'b10, 2'b11, 2'b01};
        reset_n = 1'b0;
        quad_a = '0; quad_b = '0; zero = '0; err_clr = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_count", count, 0);
        check("rst_err", err, 0);
        check("rst_vel", vel, 0);
        check("rst_vel_valid", vel_valid, 0);
        reset_n = 1'b1;
        tick(2);
        mon_en = 1;

        // Clean +1 sequence on ch0, first change LAT cycles after the pin edge.
        for (int k = 0; k < 8; k++) do_step(0, 1, 10);
        check("t1_count0", count[7:0], 8);
        check("t1_count1", count[15:8], 0);
        check("t1_err", err, 0);

        // Short glitch is filtered; a 3-cycle pulse is one step out and back.
        glitch(0, 2'b10, 2);
        check("t2_glitch_count0", count[7:0], 8);
        orig = m_ab[0];
        apply(0, orig ^ 2'b10, cyc + LAT);
        tick(3);
        apply(0, orig, cyc + LAT);
        tick(10);
        check("t2_pulse_count0", count[7:0], 8);

        // Wrap boundaries.
        while (m_pos[0] != 127) do_step(0, 1, 4);
        tick(4);
        check("t3_count_7f", count[7:0], 8'h7F);
        do_step(0, 1, 10);
        check("t3_count_80", count[7:0], 8'h80);
        zero_pulse(0, 4);
        check("t3_zero", count[7:0], 0);
        do_step(0, -1, 10);
        check("t3_count_ff", count[7:0], 8'hFF);

        // Illegal transition on ch1; set beats a coincident clear.
        apply(1, m_ab[1] ^ 2'b11, cyc + LAT);
        tick(10);
        check("t4_err1_set", err[1], 1);
        check("t4_count1", count[15:8], 0);
        apply(1, m_ab[1] ^ 2'b11, cyc + LAT);
        tick(LAT - 1);
        err_clr[1] = 1'b1;
        tick(1);
        err_clr[1] = 1'b0;
        tick(5);
        check("t4_err1_kept", err[1], 1);
        clr_pulse(1, 5);
        check("t4_err1_clr", err[1], 0);

        // zero held on the cycle a step lands wins; prev state still advances.
        do_step(0, 1, 10);
        do_step(0, 1, 10);
        c  = cyc;
        ns = gray_tab[(m_idx[0] + 1) % 4];
        m_idx[0] = idx_of(ns);
        m_ab[0]  = ns;
        m_pos[0] = 0;
        quad_a[0] = ns[1];
        quad_b[0] = ns[0];
        push_expect(c + LAT);
        tick(LAT - 1);
        zero[0] = 1'b1;
        tick(1);
        zero[0] = 1'b0;
        tick(5);
        check("t5_zero_beats_step", count[7:0], 0);
        do_step(0, 1, 10);
        check("t5_step_after_zero", count[7:0], 1);

        // Asynchronous reset in the middle of activity.
        apply(1, m_ab[1] ^ 2'b11, cyc + LAT);
        tick(10);
        do_step(0, 1, 3);
        mon_en = 0;
        #2;
        reset_n = 1'b0;
        #1;
        check("t5_rst_count", count, 0);
        check("t5_rst_err", err, 0);
        check("t5_rst_vel", vel, 0);
        check("t5_rst_vel_valid", vel_valid, 0);
        quad_a = '0; quad_b = '0;
        exp_q.delete();
        model_reset();
        tick(3);
        reset_n = 1'b1;
        tick(1);
        mon_en = 1;

`ifdef QUAD_VELOCITY_EN
        vel_chk_en = 1;
        for (int k = 0; k < 5; k++) do_step(0, 1, 4);
        vel_q.push_back(sat4(5));
        wait_vel();
        tick(1);
        for (int k = 0; k < 12; k++) do_step(0, 1, 4);
        vel_q.push_back(sat4(12));
        wait_vel();
        tick(1);
        for (int k = 0; k < 12; k++) do_step(0, -1, 4);
        vel_q.push_back(sat4(-12));
        wait_vel();
        tick(1);
        vel_chk_en = 0;
`endif

        // Randomised traffic against the model.
        for (int k = 0; k < 150; k++) begin
            op   = $urandom_range(0, 9);
            ch   = $urandom_range(0, 1);
            hold = $urandom_range(7, 10);
            dir  = ($urandom_range(0, 1) == 1) ? 1 : -1;
            if (op <= 5) begin
                do_step(ch, dir, hold);
            end else if (op == 6) begin
                apply(ch, m_ab[ch] ^ 2'b11, cyc + LAT);
                tick(hold);
            end else if (op == 7) begin
                zero_pulse(ch, hold);
            end else if (op == 8) begin
                clr_pulse(ch, hold);
            end else begin
                glitch(ch, (dir == 1) ? 2'b10 : 2'b01, $urandom_range(1, 2));
            end
        end
        tick(10);
        check("final_count", count, {8'(m_pos[1]), 8'(m_pos[0])});
        check("final_err", err, m_err);
        check("pending_events", exp_q.size(), 0);
`ifdef QUAD_VELOCITY_EN
        check("pending_vel", vel_q.size(), 0);
`else
        check("vel_idle", vel_bad, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
